// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Owns the ID/EX pipeline register and the front-end stall/flush control.
//   It detects load-use hazards (load result needed by the very next
//   instruction) and flag-dependent-branch hazards (branch in ID while the
//   flag-writing instruction is still in EX). On a hazard it freezes PC and
//   IF/ID and loads bubbles into ID/EX. A taken branch flushes IF/ID.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
//     When defined, adds output Stall_Count, a saturating count of stall cycles.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   IF_ID_RegisterRs/Rt/Rd   register specifiers of the instruction in ID
//   ID_Regwrite/MemRead/MemWrite/UsesRt/FlagWrite/Branch/BranchTaken
//                            decoded controls of the instruction in ID
//   ID_EX_RegisterRs/Rt/Rd   registered specifiers, to the forwarding unit
//   ID_EX_Regwrite/MemRead/MemWrite/FlagWrite
//                            registered controls
//   PC_Write, IF_ID_Write    front-end enables (0 while stalled or in reset)
//   IF_ID_Flush              zero IF/ID at the next edge (taken branch)
//   Stall                    a stall is active this cycle
//   Stall_Count              stall-cycle counter (HAZARD_PERF_CNT_EN only)
//
// Handshake: there is no valid/ready pair here. Stall=1 means that this
// cycle's ID instruction is held (PC_Write=IF_ID_Write=0) and ID/EX takes a
// bubble at the next edge. Stall=0 means ID/EX takes the ID instruction.
module hazard_stall_unit #(
    parameter int REG_W        = 4,
    parameter int STALL_CYCLES = 1,
    parameter int PERF_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IF_ID_RegisterRs,
    input  logic [REG_W-1:0] IF_ID_RegisterRt,
    input  logic [REG_W-1:0] IF_ID_RegisterRd,
    input  logic             ID_Regwrite,
    input  logic             ID_MemRead,
    input  logic             ID_MemWrite,
    input  logic             ID_UsesRt,
    input  logic             ID_FlagWrite,
    input  logic             ID_Branch,
    input  logic             ID_BranchTaken,
    output logic [REG_W-1:0] ID_EX_RegisterRs,
    output logic [REG_W-1:0] ID_EX_RegisterRt,
    output logic [REG_W-1:0] ID_EX_RegisterRd,
    output logic             ID_EX_Regwrite,
    output logic             ID_EX_MemRead,
    output logic             ID_EX_MemWrite,
    output logic             ID_EX_FlagWrite,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             Stall
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] Stall_Count
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FH_STALL = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic [REG_W-1:0] rs_q, rt_q, rd_q, rs_d, rt_d, rd_d;
    logic             regwrite_q, memread_q, memwrite_q, flagwrite_q;
    logic             regwrite_d, memread_d, memwrite_d, flagwrite_d;

    logic rs_match, rt_match, lu_hazard, fh_hazard, stall_raw;

    // Load-use: a load in EX targeting a non-R0 register read by ID.
    // A store whose data (Rt) is the only match is covered by MEM-MEM
    // forwarding, so it does not stall.
    assign rs_match  = (rd_q == IF_ID_RegisterRs);
    assign rt_match  = ID_UsesRt && (rd_q == IF_ID_RegisterRt);
    assign lu_hazard = memread_q && regwrite_q && (rd_q != '0) &&
                       (rs_match || (rt_match && !ID_MemWrite));
    assign fh_hazard = ID_Branch && flagwrite_q;

    // Hazards are only looked at in RUN; a stall sequence in progress is
    // never restarted by the instruction it is holding.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        case (state_q)
            RUN: begin
                if (lu_hazard) begin
                    stall_raw = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_d = LU_STALL;
                        cnt_d   = 3'(STALL_CYCLES - 1);
                    end
                end else if (fh_hazard) begin
                    stall_raw = 1'b1;
                    state_d   = FH_STALL;
                end
            end
            LU_STALL: begin
                stall_raw = 1'b1;
                if (cnt_q <= 3'd1) begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            FH_STALL: begin
                stall_raw = 1'b1;
                state_d   = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // ID/EX next value: bubble on stall, otherwise the ID instruction.
    always_comb begin
        rs_d        = IF_ID_RegisterRs;
        rt_d        = IF_ID_RegisterRt;
        rd_d        = IF_ID_RegisterRd;
        regwrite_d  = ID_Regwrite;
        memread_d   = ID_MemRead;
        memwrite_d  = ID_MemWrite;
        flagwrite_d = ID_FlagWrite;
        if (stall_raw) begin
            rs_d        = '0;
            rt_d        = '0;
            rd_d        = '0;
            regwrite_d  = 1'b0;
            memread_d   = 1'b0;
            memwrite_d  = 1'b0;
            flagwrite_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= 3'd0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            flagwrite_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            regwrite_q  <= regwrite_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            flagwrite_q <= flagwrite_d;
        end
    end

    assign ID_EX_RegisterRs = rs_q;
    assign ID_EX_RegisterRt = rt_q;
    assign ID_EX_RegisterRd = rd_q;
    assign ID_EX_Regwrite   = regwrite_q;
    assign ID_EX_MemRead    = memread_q;
    assign ID_EX_MemWrite   = memwrite_q;
    assign ID_EX_FlagWrite  = flagwrite_q;

    // Front-end controls are all held low while reset is asserted.
    assign Stall       = rst_n && stall_raw;
    assign PC_Write    = rst_n && !stall_raw;
    assign IF_ID_Write = rst_n && !stall_raw;
    // A branch held by a stall is acted on only once it proceeds.
    assign IF_ID_Flush = rst_n && ID_Branch && ID_BranchTaken && !stall_raw;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_raw && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign Stall_Count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit. Two instances share the stimulus:
// u_dut1 (STALL_CYCLES=1, PERF_W=4) and u_dut3 (STALL_CYCLES=3).
module tb_hazard_stall_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] rs, rt, rd;
    logic       rw, mr, mw, ut, fw, br, bt;

    logic [3:0] o1_rs, o1_rt, o1_rd, o3_rs, o3_rt, o3_rd;
    logic       o1_rw, o1_mr, o1_mw, o1_fw, o1_pcw, o1_ifw, o1_fl, o1_st;
    logic       o3_rw, o3_mr, o3_mw, o3_fw, o3_pcw, o3_ifw, o3_fl, o3_st;
`ifdef HAZARD_PERF_CNT_EN
    logic [3:0]  sc1;
    logic [15:0] sc3;
`endif

    int passed = 0;
    int total  = 0;

    hazard_stall_unit #(.REG_W(4), .STALL_CYCLES(1), .PERF_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .IF_ID_RegisterRd(rd),
        .ID_Regwrite(rw), .ID_MemRead(mr), .ID_MemWrite(mw), .ID_UsesRt(ut),
        .ID_FlagWrite(fw), .ID_Branch(br), .ID_BranchTaken(bt),
        .ID_EX_RegisterRs(o1_rs), .ID_EX_RegisterRt(o1_rt), .ID_EX_RegisterRd(o1_rd),
        .ID_EX_Regwrite(o1_rw), .ID_EX_MemRead(o1_mr), .ID_EX_MemWrite(o1_mw),
        .ID_EX_FlagWrite(o1_fw), .PC_Write(o1_pcw), .IF_ID_Write(o1_ifw),
        .IF_ID_Flush(o1_fl), .Stall(o1_st)
`ifdef HAZARD_PERF_CNT_EN
        , .Stall_Count(sc1)
`endif
    );

    hazard_stall_unit #(.REG_W(4), .STALL_CYCLES(3), .PERF_W(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .IF_ID_RegisterRd(rd),
        .ID_Regwrite(rw), .ID_MemRead(mr), .ID_MemWrite(mw), .ID_UsesRt(ut),
        .ID_FlagWrite(fw), .ID_Branch(br), .ID_BranchTaken(bt),
        .ID_EX_RegisterRs(o3_rs), .ID_EX_RegisterRt(o3_rt), .ID_EX_RegisterRd(o3_rd),
        .ID_EX_Regwrite(o3_rw), .ID_EX_MemRead(o3_mr), .ID_EX_MemWrite(o3_mw),
        .ID_EX_FlagWrite(o3_fw), .PC_Write(o3_pcw), .IF_ID_Write(o3_ifw),
        .IF_ID_Flush(o3_fl), .Stall(o3_st)
`ifdef HAZARD_PERF_CNT_EN
        , .Stall_Count(sc3)
`endif
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [3:0] a_rs, input logic [3:0] a_rt, input logic [3:0] a_rd,
                       input logic a_rw, input logic a_mr, input logic a_mw, input logic a_ut,
                       input logic a_fw, input logic a_br, input logic a_bt);
        rs = a_rs; rt = a_rt; rd = a_rd;
        rw = a_rw; mr = a_mr; mw = a_mw; ut = a_ut;
        fw = a_fw; br = a_br; bt = a_bt;
    endtask

    task automatic do_reset();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        // A taken branch during reset must not flush.
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        #2;
        chk("rst_pc_write", o1_pcw, 0);
        chk("rst_ifid_write", o1_ifw, 0);
        chk("rst_stall", o1_st, 0);
        chk("rst_flush", o1_fl, 0);
        chk("rst_idex_rd", o1_rd, 0);
        chk("rst_idex_rw", o1_rw, 0);
        tick();
        tick();
        rst_n = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("run_pc_write", o1_pcw, 1);
        chk("run_ifid_write", o1_ifw, 1);
        tick();

        // Load-use on Rs: load R3, then add R6 <- R3 + R2.
        drv(1, 2, 3, 1, 1, 0, 0, 0, 0, 0);
        #2 chk("lu_load_nostall", o1_st, 0);
        tick();
        chk("lu_idex_memread", o1_mr, 1);
        chk("lu_idex_rd", o1_rd, 3);
        drv(3, 2, 6, 1, 0, 0, 1, 0, 0, 0);
        #2;
        chk("lu_stall", o1_st, 1);
        chk("lu_pc_write", o1_pcw, 0);
        chk("lu_ifid_write", o1_ifw, 0);
        chk("lu_flush", o1_fl, 0);
        tick();
        chk("lu_bubble_rw", o1_rw, 0);
        chk("lu_bubble_rd", o1_rd, 0);
        chk("lu_bubble_mr", o1_mr, 0);
        #2;
        chk("lu_after_stall", o1_st, 0);
        chk("lu_after_pcw", o1_pcw, 1);
        tick();
        chk("lu_add_rs", o1_rs, 3);
        chk("lu_add_rd", o1_rd, 6);
        chk("lu_add_rw", o1_rw, 1);

        // Store exemption: load R5, store with Rt=5 (data), Rs=2.
        drv(1, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drv(2, 5, 0, 0, 0, 1, 1, 0, 0, 0);
        #2 chk("store_rt_nostall", o1_st, 0);
        tick();
        chk("store_idex_mw", o1_mw, 1);
        chk("store_idex_rt", o1_rt, 5);

        // Store whose address (Rs) depends on the load still stalls.
        drv(1, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drv(5, 7, 0, 0, 0, 1, 1, 0, 0, 0);
        #2 chk("store_rs_stall", o1_st, 1);
        tick();
        #2 chk("store_rs_proceed", o1_st, 0);
        tick();

        // Load into R0 never creates a hazard.
        drv(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drv(0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        #2 chk("r0_nostall", o1_st, 0);
        tick();

        // Rt match with ID_UsesRt=0 does not stall.
        drv(1, 0, 4, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drv(1, 4, 9, 1, 0, 0, 0, 0, 0, 0);
        #2 chk("rt_unused_nostall", o1_st, 0);
        tick();

        // Flag-dependent branch: 2 stall cycles, then the taken flush.
        drv(1, 2, 7, 1, 0, 0, 1, 1, 0, 0);
        #2 chk("fh_flagwr_nostall", o1_st, 0);
        tick();
        chk("fh_idex_fw", o1_fw, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        #2;
        chk("fh_stall1", o1_st, 1);
        chk("fh_noflush1", o1_fl, 0);
        tick();
        #2;
        chk("fh_stall2", o1_st, 1);
        chk("fh_noflush2", o1_fl, 0);
        chk("fh_stall2_pcw", o1_pcw, 0);
        tick();
        #2;
        chk("fh_release", o1_st, 0);
        chk("fh_flush", o1_fl, 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("fh_flush_drop", o1_fl, 0);

        // STALL_CYCLES=3: load R4, then an instruction reading Rt=4.
        do_reset();
        drv(1, 0, 4, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drv(1, 4, 8, 1, 0, 0, 1, 0, 0, 0);
        #2 chk("lu3_stall1", o3_st, 1);
        tick();
        #2 chk("lu3_stall2", o3_st, 1);
        tick();
        #2;
        chk("lu3_stall3", o3_st, 1);
        chk("lu3_stall3_ifw", o3_ifw, 0);
        tick();
        #2;
        chk("lu3_release", o3_st, 0);
        chk("lu3_release_pcw", o3_pcw, 1);
        tick();
        chk("lu3_capture_rt", o3_rt, 4);
        chk("lu3_capture_rd", o3_rd, 8);

        // Reset in the middle of LU_STALL.
        drv(1, 0, 4, 1, 1, 0, 0, 0, 0, 0);
        tick();
        chk("mid_idex_rd", o3_rd, 4);
        drv(4, 0, 2, 1, 0, 0, 0, 0, 0, 0);
        #2 chk("mid_stall1", o3_st, 1);
        tick();
        #2 chk("mid_stall2", o3_st, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", o3_st, 0);
        chk("mid_rst_pcw", o3_pcw, 0);
        chk("mid_rst_idex_rw", o3_rw, 0);
        chk("mid_rst_idex_rs", o3_rs, 0);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_stall", o3_st, 0);
        chk("mid_rel_pcw", o3_pcw, 1);
        tick();
        #2 chk("mid_no_resume", o3_st, 0);
        chk("mid_capture_rs", o3_rs, 4);

`ifdef HAZARD_PERF_CNT_EN
        // 10 flag-branch pairs = 20 stall cycles; a 4-bit counter stops at 15.
        do_reset();
        #2 chk("perf_reset", sc1, 0);
        for (int i = 0; i < 10; i++) begin
            drv(1, 2, 7, 1, 0, 0, 1, 1, 0, 0);
            tick();
            drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            tick();
            tick();
            tick();
            if (i == 0) chk("perf_first", sc1, 2);
            if (i == 6) chk("perf_fourteen", sc1, 14);
        end
        chk("perf_saturate", sc1, 15);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Owns the ID/EX pipeline register and the stall/flush control for the front end.
- Sits directly upstream of the forwarding unit and supplies its registered ID_EX_RegisterRs/Rt/Rd and ID_EX_Regwrite.
- Detects load-use and flag-dependent-branch hazards the forwarding paths cannot cover.
- On a hazard it freezes PC and IF/ID and injects bubbles into ID/EX; a taken branch flushes IF/ID.

Parameters:
- REG_W, 4, register-specifier width (16 architectural registers; R0 is hardwired zero).
- STALL_CYCLES, 1, load-use stall length in cycles (legal range 1..7).
- PERF_W, 16, stall-counter width (optional feature only).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- IF_ID_RegisterRs  in  REG_W  source 1 of the instruction in ID
- IF_ID_RegisterRt  in  REG_W  source 2 of the instruction in ID
- IF_ID_RegisterRd  in  REG_W  destination of the instruction in ID
- ID_Regwrite  in  1  ID instruction writes Rd
- ID_MemRead  in  1  ID instruction is a load
- ID_MemWrite  in  1  ID instruction is a store (Rt = store data)
- ID_UsesRt  in  1  ID instruction reads Rt
- ID_FlagWrite  in  1  ID instruction updates flags
- ID_Branch  in  1  ID instruction is a conditional branch
- ID_BranchTaken  in  1  branch resolved taken in ID
- ID_EX_RegisterRs  out  REG_W  registered Rs, to the forwarding unit
- ID_EX_RegisterRt  out  REG_W  registered Rt, to the forwarding unit
- ID_EX_RegisterRd  out  REG_W  registered Rd, to the forwarding unit
- ID_EX_Regwrite  out  1  registered write enable
- ID_EX_MemRead  out  1  registered load flag
- ID_EX_MemWrite  out  1  registered store flag
- ID_EX_FlagWrite  out  1  registered flag-write
- PC_Write  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  zero IF/ID at the next edge
- Stall  out  1  a stall is active this cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - All ID_EX_* outputs are 0 and the FSM is in RUN.
  - PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, Stall=0 while reset is asserted.
  - After release the block is in RUN and PC_Write=IF_ID_Write=1.
- Load-use hazard (LU), combinational:
  - Condition: ID_EX_MemRead & ID_EX_Regwrite & ID_EX_RegisterRd!=0, and either (ID_EX_RegisterRd==IF_ID_RegisterRs) or (ID_UsesRt & ID_EX_RegisterRd==IF_ID_RegisterRt).
  - Exemption: if ID_MemWrite=1 and the match is on Rt only, there is no LU; MEM-MEM forwarding covers store data.
- Flag hazard (FH): ID_Branch & ID_EX_FlagWrite.
- FSM states: RUN, LU_STALL, FH_STALL. The stall counter is 3 bits.
  - RUN + LU: stall this cycle. If STALL_CYCLES>1, go to LU_STALL with cnt=STALL_CYCLES-1.
  - RUN + FH (no LU): stall this cycle and go to FH_STALL.
  - LU_STALL: stall; decrement cnt; return to RUN when cnt reaches 1.
  - FH_STALL: exactly one further stall cycle, then RUN.
  - A stalling cycle never re-triggers a new stall sequence from the same instruction. Hazard conditions are re-evaluated only in RUN.
- Stall cycle outputs: PC_Write=0, IF_ID_Write=0, Stall=1, IF_ID_Flush=0. At the next edge ID/EX loads a bubble (all fields and controls 0).
- Non-stall cycle: ID/EX captures IF_ID_* and ID_* at the edge; PC_Write=IF_ID_Write=1.
- Branch flush: IF_ID_Flush = ID_Branch & ID_BranchTaken & ~Stall. While stalled the branch is not acted on; it is re-evaluated once it proceeds.
- Priority: LU > FH > flush.
- Reset mid-stall: immediate return to RUN; the counter clears.
- R0 as destination never creates a hazard.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds output Stall_Count [PERF_W-1:0], reset to 0.
  - Increments on every cycle with Stall=1 and saturates at all-ones (no wrap).
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-operation: drive rst_n low during LU_STALL with STALL_CYCLES=3 -> all ID_EX_* are 0 immediately; after release PC_Write=1 and Stall=0.
- Load-use stall: load R3 in EX; ID instruction has Rs=3 -> exactly one cycle with Stall=1, PC_Write=0, IF_ID_Write=0. Next cycle ID_EX_Regwrite=0 and ID_EX_RegisterRd=0 (bubble). The add then enters ID/EX with Rs=3.
- Store exemption and R0: load R5, then store with Rt=5, Rs=2 -> no stall. Load to R0, then Rs=0 -> no stall.
- STALL_CYCLES=3: load R4, then Rt=4 with ID_UsesRt=1 -> Stall=1 for exactly 3 consecutive cycles, then a normal ID/EX capture.
- Flag branch: ID_EX_FlagWrite=1 with a branch in ID -> 2 stall cycles. Then ID_BranchTaken=1 -> IF_ID_Flush=1 for 1 cycle. Flush is never asserted while Stall=1.
- HAZARD_PERF_CNT_EN with PERF_W=4: force 20 stall cycles -> Stall_Count saturates at 15.
